// File: rtl/uart_conf_arb_if.sv
// Bundles the two requester channels, the downstream config port and the status outputs.
// The master modport is the arbiter's view; the slave modport is the view of whatever drives and observes it.
interface uart_conf_arb_if #(
   parameter int CONFIG_WIDTH = 32
);
   logic                    a_req;
   logic [CONFIG_WIDTH-1:0] a_data;
   logic                    a_ack;
   logic                    a_err;
   logic                    b_req;
   logic [CONFIG_WIDTH-1:0] b_data;
   logic                    b_ack;
   logic                    b_err;
   logic                    m_conf_req;
   logic                    m_conf_ack;
   logic [CONFIG_WIDTH-1:0] m_conf_data;
   logic                    busy;
   logic                    grant_b;
   logic [CONFIG_WIDTH-1:0] shadow;

   modport master (
      input  a_req, a_data, b_req, b_data, m_conf_ack,
      output a_ack, a_err, b_ack, b_err, m_conf_req, m_conf_data, busy, grant_b, shadow
   );

   modport slave (
      output a_req, a_data, b_req, b_data, m_conf_ack,
      input  a_ack, a_err, b_ack, b_err, m_conf_req, m_conf_data, busy, grant_b, shadow
   );
endinterface

// File: rtl/uart_conf_arb.sv
// Round-robin arbiter giving two requesters write access to one downstream config register,
// with a per-transfer ISSUE timeout and a shadow copy of the last successfully written word.
module uart_conf_arb #(
   parameter int CONFIG_WIDTH = 32,
   parameter int TIMEOUT      = 16
) (
   input logic              clock,
   input logic              reset,
   uart_conf_arb_if.master  bus
);
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ISSUE   = 2'd1;
   localparam logic [1:0] ST_RELEASE = 2'd2;
   localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

   logic [1:0]              state;
   logic [7:0]              timer;
   logic                    a_ack_q, a_err_q, b_ack_q, b_err_q;
   logic                    m_conf_req_q, busy_q, grant_b_q;
   logic [CONFIG_WIDTH-1:0] m_conf_data_q, shadow_q;
   logic                    pick_b;
   logic                    timed_out;

   // Contention goes to whoever did not own the previous transfer.
   assign pick_b    = bus.b_req & (~bus.a_req | ~grant_b_q);
   assign timed_out = (timer == TIMER_LAST) & ~bus.m_conf_ack;

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= ST_IDLE;
         timer         <= '0;
         a_ack_q       <= 1'b0;
         a_err_q       <= 1'b0;
         b_ack_q       <= 1'b0;
         b_err_q       <= 1'b0;
         m_conf_req_q  <= 1'b0;
         busy_q        <= 1'b0;
         grant_b_q     <= 1'b1;
         m_conf_data_q <= '0;
         shadow_q      <= CONFIG_WIDTH'('h60);
      end else begin
         a_ack_q <= 1'b0;
         a_err_q <= 1'b0;
         b_ack_q <= 1'b0;
         b_err_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.a_req || bus.b_req) begin
                  state         <= ST_ISSUE;
                  m_conf_req_q  <= 1'b1;
                  busy_q        <= 1'b1;
                  grant_b_q     <= pick_b;
                  m_conf_data_q <= pick_b ? bus.b_data : bus.a_data;
                  timer         <= '0;
               end
            end
            ST_ISSUE: begin
               timer <= timer + 8'd1;
               // An ack landing in the final timer cycle still counts as success.
               if (bus.m_conf_ack || timed_out) begin
                  state        <= ST_RELEASE;
                  m_conf_req_q <= 1'b0;
                  a_ack_q      <= ~grant_b_q;
                  b_ack_q      <= grant_b_q;
                  a_err_q      <= ~grant_b_q & timed_out;
                  b_err_q      <= grant_b_q & timed_out;
                  if (bus.m_conf_ack) begin
                     shadow_q <= m_conf_data_q;
                  end
               end
            end
            ST_RELEASE: begin
               state  <= ST_IDLE;
               busy_q <= 1'b0;
            end
            default: begin
               state        <= ST_IDLE;
               m_conf_req_q <= 1'b0;
               busy_q       <= 1'b0;
            end
         endcase
      end
   end

   assign bus.a_ack       = a_ack_q;
   assign bus.a_err       = a_err_q;
   assign bus.b_ack       = b_ack_q;
   assign bus.b_err       = b_err_q;
   assign bus.m_conf_req  = m_conf_req_q;
   assign bus.m_conf_data = m_conf_data_q;
   assign bus.busy        = busy_q;
   assign bus.grant_b     = grant_b_q;
   assign bus.shadow      = shadow_q;
endmodule

// File: doc/uart_conf_arb.md
UART_CONF_ARB -- requirements
Module: uart_conf_arb

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
  CONFIG_WIDTH  32  width of configuration words
  TIMEOUT       16  maximum number of ISSUE cycles allowed per transfer (legal range 2..255)
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
  clock        in   1             clock; all state changes on its rising edge
  reset        in   1             reset, synchronous, active-high
  a_req        in   1             requester A write request; held until a_ack
  a_data       in   CONFIG_WIDTH  requester A write word; stable while a_req=1
  a_ack        out  1             one-cycle completion pulse to A
  a_err        out  1             valid with a_ack; 1 = transfer timed out
  b_req        in   1             requester B write request
  b_data       in   CONFIG_WIDTH  requester B write word
  b_ack        out  1             one-cycle completion pulse to B
  b_err        out  1             valid with b_ack; 1 = timeout
  m_conf_req   out  1             downstream configuration register request
  m_conf_ack   in   1             downstream acknowledge
  m_conf_data  out  CONFIG_WIDTH  word presented downstream
  busy         out  1             1 while the state is not IDLE
  grant_b      out  1             owner of the current or last transfer (0 = A, 1 = B)
  shadow       out  CONFIG_WIDTH  last word successfully written downstream

Function
REQ-003 The block SHALL implement an FSM with three states: IDLE, ISSUE and RELEASE.
REQ-004 In IDLE with any request pending, the block SHALL grant one requester, latch that requester's data into m_conf_data, set grant_b, clear the timer and move to ISSUE.
REQ-005 Arbitration SHALL be round-robin: when both requests are pending, the requester not granted last wins; with a single request pending, that requester wins.
REQ-006 In ISSUE, m_conf_req SHALL be 1 and m_conf_data SHALL stay stable.
REQ-007 In ISSUE, a cycle with m_conf_ack=1 SHALL complete the transfer: shadow <= m_conf_data, err flag <= 0, next state RELEASE.
REQ-008 In ISSUE, the timer SHALL increment each cycle; a cycle with timer=TIMEOUT-1 and m_conf_ack=0 SHALL set err flag <= 1, leave shadow unchanged, and move to RELEASE.
REQ-009 If m_conf_ack=1 occurs in the timeout cycle, the block SHALL treat it as success (REQ-007 wins).
REQ-010 In RELEASE, m_conf_req SHALL be 0 and the granted requester's ack SHALL be 1 for exactly one cycle with its err output valid; the other requester's ack SHALL stay 0; next state IDLE.
REQ-011 No arbitration SHALL occur in RELEASE; a requester SHALL deassert req in the cycle after its ack, so the new request is first sampled in IDLE.
REQ-012 All outputs SHALL be registered; m_conf_req SHALL be 1 exactly while the state is ISSUE.
REQ-013 m_conf_ack sampled in IDLE or RELEASE SHALL be ignored.
REQ-014 Latency with a downstream that acks one cycle after seeing req: req at cycle 0, m_conf_req=1 in cycles 1-2, ack pulse in cycle 3, IDLE in cycle 4, next grant possible at cycle 4.
REQ-015 x_err SHALL be 0 whenever x_ack=0.

Reset
REQ-016 On reset the block SHALL set: state IDLE; m_conf_req, a_ack, b_ack, a_err, b_err and busy to 0; m_conf_data and timer to 0; shadow to 'h60; and grant_b to 1, so that A wins the first contention.
REQ-017 Reset asserted in ISSUE or RELEASE SHALL abort the transfer with no ack pulse and no shadow update; m_conf_req SHALL be 0 in the cycle after reset.

Verification
REQ-018 The bench SHALL cover the following directed scenarios, one per line: stimulus -> required response.
  Reset -> shadow='h60, grant_b=1, all handshake outputs 0.
  a_req with a_data='h1234 and a downstream that acks after 1 cycle -> m_conf_data='h1234, a_ack at cycle 3 with a_err=0, shadow='h1234, m_conf_req high for exactly 2 cycles.
  a_req and b_req raised together after reset -> A is served first; B is granted in the IDLE cycle after a_ack; grant_b then =1.
  b_req with the downstream never acking, TIMEOUT=16 -> m_conf_req high 16 cycles, then b_ack=1 with b_err=1, shadow unchanged.
  m_conf_ack first rises in ISSUE cycle 16 -> success, err=0.
  Reset asserted in ISSUE -> no ack, m_conf_req=0 next cycle, shadow='h60.
